down_counter: RTL and testbench

Loadable 4-bit countdown timer for the display subsystem. It decrements once per `slow_clk` enable pulse and drives a hex digit on the 7-segment output. It is the down-counting counterpart to the existing up counter: same clock, same tick enable, same digit output path. A small FSM handles the load/start/stop/expire sequence and raises `done` at terminal count.

---
 rtl/down_counter_pkg.sv | 20 ++
 rtl/down_counter_hex_to_seg.sv | 14 +
 rtl/down_counter.sv | 108 ++++++++++
 tb/tb_down_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable 4-bit countdown timer and its
// 7-segment digit decoder.
package down_counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } dc_state_t;

   localparam logic [3:0] DC_MAX = 4'd15;

   // Active-high segments {g,f,e,d,c,b,a}, indexed by hex digit.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/down_counter_hex_to_seg.sv
// Combinational hex digit to 7-segment lookup driven from the shared table.
module hex_to_seg
   import down_counter_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   // Table lookup for the digit.
   always_comb begin
      seg = SEG_TABLE[hex];
   end

endmodule

// File: rtl/down_counter.sv
// Loadable 4-bit countdown timer with load/start/stop/expire FSM and hex digit output.
// Build option DOWN_COUNTER_AUTORELOAD_EN: reload at terminal count, done becomes a pulse.
module down_counter
   import down_counter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       slow_clk,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] val,
   output logic [6:0] seg,
   output logic       busy,
   output logic       done
);

   dc_state_t  state_q, state_d;
   logic [3:0] count_q, count_d;
   logic [3:0] reload_q, reload_d;
   logic       done_q, done_d;

   // Next-state, count and done logic in priority order load > stop > start > tick.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE, PAUSE: begin
               if (start) begin
                  if (count_q != 4'd0) begin
                     state_d = RUN;
                  end else begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            RUN: begin
               if (stop) begin
                  state_d = PAUSE;
               end else if (start) begin
                  state_d = RUN;
               end else if (slow_clk) begin
                  if (count_q == 4'd1) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                     count_d = reload_q;
                     done_d  = 1'b1;
`else
                     count_d = 4'd0;
                     state_d = DONE;
                     done_d  = 1'b1;
`endif
                  end else if (count_q != 4'd0) begin
                     count_d = count_q - 4'd1;
                  end else begin
                     count_d = 4'd0;
                  end
               end else begin
                  state_d = RUN;
               end
            end
            DONE: begin
               count_d = 4'd0;
               done_d  = 1'b1;
            end
            default: begin
               state_d = IDLE;
               count_d = 4'd0;
            end
         endcase
      end
   end

   // State, count, reload and done registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= 4'd0;
         reload_q <= 4'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign val  = count_q;
   assign busy = (state_q == RUN);
   assign done = done_q;

   hex_to_seg u_hex_to_seg (
      .hex (count_q),
      .seg (seg)
   );

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter; inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_down_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       slow_clk = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] val;
   logic [6:0] seg;
   logic       busy;
   logic       done;

   int vectors = 0;
   int miscompares = 0;

   down_counter dut (
      .clk      (clk),
      .reset    (reset),
      .slow_clk (slow_clk),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .stop     (stop),
      .val      (val),
      .seg      (seg),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [3:0] v);
      load = 1'b1; load_val = v; cyc(); load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic do_tick();
      slow_clk = 1'b1; cyc(); slow_clk = 1'b0;
   endtask

   initial begin
      // Reset then idle
      reset = 1'b1; cyc(); reset = 1'b0;
      repeat (10) cyc();
      check("rst_val", 32'(val), 32'd0);
      check("rst_seg", 32'(seg), 32'h3F);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);

      // stop and start with zero count behaviour below; first a stop in IDLE is inert
      stop = 1'b1; cyc(); stop = 1'b0;
      check("idle_stop_busy", 32'(busy), 32'd0);

`ifndef DOWN_COUNTER_AUTORELOAD_EN
      // Load 3, count down to expiry with ticks 4 cycles apart
      do_load(4'd3);
      check("l3_val", 32'(val), 32'd3);
      check("l3_seg", 32'(seg), 32'h4F);
      check("l3_busy", 32'(busy), 32'd0);
      do_start();
      check("l3_start_busy", 32'(busy), 32'd1);
      check("l3_start_val", 32'(val), 32'd3);
      do_tick();
      check("t1_val", 32'(val), 32'd2);
      check("t1_seg", 32'(seg), 32'h5B);
      repeat (3) cyc();
      check("t1_hold", 32'(val), 32'd2);
      do_tick();
      check("t2_val", 32'(val), 32'd1);
      check("t2_seg", 32'(seg), 32'h06);
      check("t2_done", 32'(done), 32'd0);
      repeat (3) cyc();
      do_tick();
      check("t3_val", 32'(val), 32'd0);
      check("t3_done", 32'(done), 32'd1);
      check("t3_busy", 32'(busy), 32'd0);
      do_tick();
      do_tick();
      check("post_tick_val", 32'(val), 32'd0);
      check("post_tick_done", 32'(done), 32'd1);
      do_start();
      check("done_start_busy", 32'(busy), 32'd0);
      check("done_start_done", 32'(done), 32'd1);
`endif

      // Load 9, two ticks, stop with simultaneous tick, resume
      do_load(4'd9);
      check("l9_done", 32'(done), 32'd0);
      check("l9_seg", 32'(seg), 32'h6F);
      do_start();
      do_tick();
      do_tick();
      check("l9_t2_val", 32'(val), 32'd7);
      stop = 1'b1; slow_clk = 1'b1; cyc(); stop = 1'b0; slow_clk = 1'b0;
      check("stop_val", 32'(val), 32'd7);
      check("stop_busy", 32'(busy), 32'd0);
      do_tick();
      check("pause_tick_val", 32'(val), 32'd7);
      do_start();
      check("resume_busy", 32'(busy), 32'd1);
      do_tick();
      check("resume_val", 32'(val), 32'd6);
      check("resume_seg", 32'(seg), 32'h7D);

      // Load 0 then start goes straight to DONE
      do_load(4'd0);
      check("l0_busy", 32'(busy), 32'd0);
      check("l0_done", 32'(done), 32'd0);
      do_start();
      check("l0_start_done", 32'(done), 32'd1);
      check("l0_start_busy", 32'(busy), 32'd0);
      check("l0_start_val", 32'(val), 32'd0);

      // Mid-run load aborts the run
      do_load(4'd4);
      do_start();
      do_tick();
      do_tick();
      check("mid_val", 32'(val), 32'd2);
      do_load(4'd5);
      check("abort_val", 32'(val), 32'd5);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_seg", 32'(seg), 32'h6D);
      do_tick();
      check("abort_idle_tick", 32'(val), 32'd5);

      // Reset mid-run
      do_start();
      do_tick();
      check("pre_rst_val", 32'(val), 32'd4);
      reset = 1'b1; start = 1'b1; slow_clk = 1'b1; cyc();
      reset = 1'b0; start = 1'b0; slow_clk = 1'b0;
      check("mrst_val", 32'(val), 32'd0);
      check("mrst_seg", 32'(seg), 32'h3F);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_done", 32'(done), 32'd0);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
      // Auto-reload period of 2 with back-to-back ticks
      do_load(4'd2);
      do_start();
      do_tick();
      check("ar_t1_val", 32'(val), 32'd1);
      check("ar_t1_done", 32'(done), 32'd0);
      do_tick();
      check("ar_t2_val", 32'(val), 32'd2);
      check("ar_t2_done", 32'(done), 32'd1);
      check("ar_t2_busy", 32'(busy), 32'd1);
      do_tick();
      check("ar_t3_val", 32'(val), 32'd1);
      check("ar_t3_done", 32'(done), 32'd0);
      do_tick();
      check("ar_t4_val", 32'(val), 32'd2);
      check("ar_t4_done", 32'(done), 32'd1);
      cyc();
      check("ar_pulse_end", 32'(done), 32'd0);
      do_tick();
      check("ar_t5_val", 32'(val), 32'd1);
      check("ar_t5_busy", 32'(busy), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
